// File: rtl/jk_bank_sequencer.sv
// Command sequencer driving the per-bit J/K inputs of an external JK flip-flop bank.
// Single-step ops take one EXEC cycle; COUNT_UP/SHIFT_L/COUNT_DOWN take cmd_cnt steps.
module jk_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP        = 3'b000;
    localparam logic [2:0] OP_CLEAR      = 3'b001;
    localparam logic [2:0] OP_SET        = 3'b010;
    localparam logic [2:0] OP_TOGGLE     = 3'b011;
    localparam logic [2:0] OP_LOAD       = 3'b100;
    localparam logic [2:0] OP_COUNT_UP   = 3'b101;
    localparam logic [2:0] OP_SHIFT_L    = 3'b110;
    localparam logic [2:0] OP_COUNT_DOWN = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic             isMulti;
    logic             lastStep;
    logic [WIDTH-1:0] jNext;
    logic [WIDTH-1:0] kNext;
    logic [WIDTH-1:0] shiftIn;
    logic             carryUp;
    logic             borrowDown;

    assign isMulti  = (op_q == OP_COUNT_UP) || (op_q == OP_SHIFT_L) || (op_q == OP_COUNT_DOWN);
    assign lastStep = !isMulti || (rem_q <= CNT_W'(1));
    assign rem_d    = rem_q - CNT_W'(1);
    assign shiftIn  = {q_i[WIDTH-2:0], data_q[0]};

    // Control FSM; handshake and status outputs are registered so they change only on clk or preset.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        data_q  <= cmd_data;
                        rem_q   <= cmd_cnt;
                        state_q <= EXEC;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (isMulti && rem_q != '0) begin
                        rem_q <= rem_d;
                    end
                    if (lastStep) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Per-bit J/K for the current bank step; a multi-step op with a zero count degrades to a hold.
    always_comb begin
        jNext      = '0;
        kNext      = '0;
        carryUp    = 1'b1;
        borrowDown = 1'b1;
        if (state_q == EXEC) begin
            case (op_q)
                OP_NOP: begin
                    jNext = '0;
                    kNext = '0;
                end
                OP_CLEAR: kNext = '1;
                OP_SET:   jNext = '1;
                OP_TOGGLE: begin
                    jNext = data_q;
                    kNext = data_q;
                end
                OP_LOAD: begin
                    jNext = data_q;
                    kNext = ~data_q;
                end
                OP_COUNT_UP: begin
                    if (rem_q != '0) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            jNext[i] = carryUp;
                            kNext[i] = carryUp;
                            carryUp  = carryUp & q_i[i];
                        end
                    end
                end
                OP_SHIFT_L: begin
                    if (rem_q != '0) begin
                        jNext = shiftIn;
                        kNext = ~shiftIn;
                    end
                end
                OP_COUNT_DOWN: begin
                    if (rem_q != '0) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            jNext[i]   = borrowDown;
                            kNext[i]   = borrowDown;
                            borrowDown = borrowDown & ~q_i[i];
                        end
                    end
                end
                default: begin
                    jNext = '0;
                    kNext = '0;
                end
            endcase
        end
    end

    assign j_o       = jNext;
    assign k_o       = kNext;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: emulates the JK flop bank and checks every cycle
// against a command-level model, plus directed scenarios with literal expectations.
module tb_jk_bank_sequencer;

    logic       clk = 1'b0;
    logic       preset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] cmd_cnt = 8'h00;
    logic [7:0] bank = 8'h00;
    logic [7:0] j_o;
    logic [7:0] k_o;
    logic       busy;
    logic       done;

    int checks = 0;
    int passes = 0;
    bit modelOn = 1'b0;

    // Command-level model: phase 0 idle, 1 executing, 2 done
    int         mPhase = 0;
    int         mLeft = 0;
    logic [2:0] mOp = 3'd0;
    logic [7:0] mData = 8'h00;
    bit         mZero = 1'b0;
    logic [7:0] expBank = 8'h00;

    jk_bank_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .q_i       (bank),
        .j_o       (j_o),
        .k_o       (k_o),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // The external bank: one JK flop per bit on the shared clock, never reset.
    always @(posedge clk) begin
        bank <= (j_o & ~bank) | (~k_o & bank);
    end

    // What one bank step does to the whole register, in plain arithmetic.
    function automatic logic [7:0] stepValue(input logic [2:0] op, input logic [7:0] data,
                                             input logic [7:0] cur, input bit zeroCnt);
        case (op)
            3'd1: stepValue = 8'h00;
            3'd2: stepValue = 8'hFF;
            3'd3: stepValue = cur ^ data;
            3'd4: stepValue = data;
            3'd5: stepValue = zeroCnt ? cur : cur + 8'd1;
            3'd6: stepValue = zeroCnt ? cur : {cur[6:0], data[0]};
            3'd7: stepValue = zeroCnt ? cur : cur - 8'd1;
            default: stepValue = cur;
        endcase
    endfunction

    always @(posedge clk or posedge preset) begin
        if (preset) begin
            mPhase <= 0;
            mLeft  <= 0;
        end else begin
            case (mPhase)
                0: begin
                    if (cmd_valid) begin
                        mOp    <= cmd_op;
                        mData  <= cmd_data;
                        mZero  <= (cmd_op >= 3'd5) && (cmd_cnt == 8'd0);
                        mLeft  <= ((cmd_op >= 3'd5) && (cmd_cnt != 8'd0)) ? int'(cmd_cnt) : 1;
                        mPhase <= 1;
                    end
                end
                1: begin
                    expBank <= stepValue(mOp, mData, expBank, mZero);
                    mLeft   <= mLeft - 1;
                    if (mLeft == 1) mPhase <= 2;
                end
                default: mPhase <= 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("model ready", 32'(cmd_ready), 32'(mPhase == 0));
            checkOutput("model busy", 32'(busy), 32'(mPhase != 0));
            checkOutput("model done", 32'(done), 32'(mPhase == 2));
            checkOutput("model bank", 32'(bank), 32'(expBank));
            if (mPhase != 1) begin
                checkOutput("model j idle", 32'(j_o), 32'h0);
                checkOutput("model k idle", 32'(k_o), 32'h0);
            end
        end
    end

    // Offers a command and returns two time units after the edge that accepted it.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data, input logic [7:0] cnt);
        bit accepted = 1'b0;
        @(posedge clk);
        #2;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        checkOutput("accept", 32'(accepted), 32'h1);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
    endtask

    // Edges from accept to the cycle in which done is seen.
    task automatic waitDone(input string name, input int expSteps);
        int lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i - 1;
                break;
            end
        end
        checkOutput(name, 32'(lat), 32'(expSteps));
    endtask

    logic [7:0] upSeq   [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] downSeq [3] = '{8'h01, 8'h00, 8'hFF};

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset ready", 32'(cmd_ready), 32'h1);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset j", 32'(j_o), 32'h0);
        checkOutput("reset k", 32'(k_o), 32'h0);
        modelOn = 1'b1;
        @(posedge clk);
        #2;
        preset = 1'b0;

        applyStimulus(3'd4, 8'hA5, 8'd0);
        waitDone("load latency", 1);
        checkOutput("load bank", 32'(bank), 32'hA5);

        applyStimulus(3'd3, 8'h0F, 8'd0);
        waitDone("toggle latency", 1);
        checkOutput("toggle bank", 32'(bank), 32'hAA);

        applyStimulus(3'd1, 8'h00, 8'd0);
        waitDone("clear latency", 1);
        checkOutput("clear bank", 32'(bank), 32'h00);

        applyStimulus(3'd2, 8'h00, 8'd0);
        waitDone("set latency", 1);
        checkOutput("set bank", 32'(bank), 32'hFF);

        applyStimulus(3'd4, 8'hFD, 8'd0);
        waitDone("load2 latency", 1);
        applyStimulus(3'd5, 8'h00, 8'd4);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            checkOutput("count up step", 32'(bank), 32'(upSeq[s]));
        end
        checkOutput("count up done", 32'(done), 32'h1);

        applyStimulus(3'd4, 8'h02, 8'd0);
        waitDone("load3 latency", 1);
        applyStimulus(3'd7, 8'h00, 8'd3);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkOutput("count down step", 32'(bank), 32'(downSeq[s]));
        end
        checkOutput("count down done", 32'(done), 32'h1);

        // A zero count: one idle EXEC cycle, done in the second cycle after the accept cycle.
        applyStimulus(3'd5, 8'h00, 8'd0);
        waitDone("count zero latency", 1);
        checkOutput("count zero bank", 32'(bank), 32'hFF);

        applyStimulus(3'd4, 8'h81, 8'd0);
        waitDone("load4 latency", 1);
        applyStimulus(3'd6, 8'h01, 8'd2);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_data  = 8'h3C;
        cmd_cnt   = 8'd0;
        @(negedge clk);
        checkOutput("shift hold ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        checkOutput("shift step1", 32'(bank), 32'h03);
        @(negedge clk);
        checkOutput("shift step2", 32'(bank), 32'h07);
        checkOutput("shift done", 32'(done), 32'h1);
        @(negedge clk);
        checkOutput("held cmd ready", 32'(cmd_ready), 32'h1);
        checkOutput("held cmd bank", 32'(bank), 32'h07);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("held cmd loaded", 32'(bank), 32'h3C);

        applyStimulus(3'd1, 8'h00, 8'd0);
        waitDone("clear2 latency", 1);
        applyStimulus(3'd5, 8'h00, 8'd200);
        repeat (10) @(posedge clk);
        #2;
        preset = 1'b1;
        #1;
        checkOutput("abort ready", 32'(cmd_ready), 32'h1);
        checkOutput("abort busy", 32'(busy), 32'h0);
        checkOutput("abort done", 32'(done), 32'h0);
        checkOutput("abort j", 32'(j_o), 32'h0);
        checkOutput("abort k", 32'(k_o), 32'h0);
        @(negedge clk);
        checkOutput("abort bank", 32'(bank), 32'h0A);
        @(posedge clk);
        #2;
        preset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort no done", 32'(done), 32'h0);
        end
        checkOutput("abort bank held", 32'(bank), 32'h0A);
        applyStimulus(3'd4, 8'h5A, 8'd0);
        waitDone("post-abort latency", 1);
        checkOutput("post-abort bank", 32'(bank), 32'h5A);

        // Random traffic, with valid often held through busy periods and rare presets.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #2;
            preset    = ($urandom_range(0, 199) == 0);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_data  = 8'($urandom);
            cmd_cnt   = 8'($urandom_range(0, 5));
        end
        @(posedge clk);
        #2;
        preset    = 1'b0;
        cmd_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        modelOn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Command-driven controller for an external bank of WIDTH JK flip-flops (one ffJK per bit, sharing clk).
- Per command, drives per-bit j/k vectors so the bank clears, sets, toggles, loads, counts or shifts.
- Multi-step ops (count/shift) are sequenced internally over N clock edges.
- Sits between a valid/ready command source and the flop bank, reading the bank state back on q_i.

Parameters:
- WIDTH, 8, number of bank bits.
- CNT_W, 8, width of the step-count field.

Ports:
- clk  input  1  clock; bank flops share this clock.
- preset  input  1  reset; asynchronous, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  operation code.
- cmd_data  input  WIDTH  mask, load value, or serial-in bit (bit 0).
- cmd_cnt  input  CNT_W  step count for multi-step ops.
- q_i  input  WIDTH  current bank Q outputs.
- j_o  output  WIDTH  per-bit J to the bank.
- k_o  output  WIDTH  per-bit K to the bank.
- busy  output  1  high in EXEC and DONE.
- done  output  1  one-cycle pulse; bank holds the result.

Behaviour:
- Reset (preset=1, async):
  - state=IDLE, step counter=0, latched op/data=0.
  - j_o=0, k_o=0 (bank holds), busy=0, done=0, cmd_ready=1.
- Reset mid-operation aborts immediately. The bank keeps whatever value its last clk edge produced, and no done pulse is issued.
- States: IDLE, EXEC, DONE.
  - IDLE: cmd_ready=1, j_o=k_o=0.
    - On cmd_valid at a clk edge: latch op, data and cnt into rem, then go to EXEC.
  - EXEC: cmd_ready=0, busy=1.
    - j_o/k_o are combinational from the latched op/data and the live q_i.
    - Each clk edge in EXEC is one bank step.
    - Single-step ops and cnt=0: exactly one EXEC cycle, then DONE.
    - Multi-step ops with cnt≥1: rem decrements each edge; leave for DONE on the edge where rem==1 (exactly cnt steps).
  - DONE: done=1, busy=1, cmd_ready=0, j_o=k_o=0. Next edge goes to IDLE.
    - cmd_valid is ignored in EXEC and DONE.
- Latency:
  - Command accepted at edge T.
  - Bank updated at T+1 (single-step) or T+cnt (multi-step).
  - done is high during the cycle after the final step edge.
  - Next accept is possible one cycle after done.
- Op codes (bit i, i=0..WIDTH-1):
  - 000 NOP: j=0, k=0. One EXEC cycle; the bank is unchanged.
  - 001 CLEAR: j=0, k=1.
  - 010 SET: j=1, k=0.
  - 011 TOGGLE: j=k=data[i]. Bits with 0 in the mask hold.
  - 100 LOAD: j=data[i], k=~data[i].
  - 101 COUNT_UP: j=k=&q_i[i-1:0], with bit 0 always toggling. Modulo 2^WIDTH (all-ones wraps to 0).
  - 110 SHIFT_L: bit 0 gets data[0] (j=data[0], k=~data[0]). Bit i gets q_i[i-1] (j=q_i[i-1], k=~q_i[i-1]). The MSB is discarded.
  - 111 COUNT_DOWN: j=k=~|q_i[i-1:0], with bit 0 always toggling. 0 wraps to all-ones.
  - For single-step ops, cnt is ignored.
  - For COUNT_UP/SHIFT_L/COUNT_DOWN, cnt=0 behaves as NOP: j=k=0 for one EXEC cycle, then done.
- No j_o/k_o glitch constraints beyond settling before the clk edge. q_i is assumed synchronous to clk.

Test Plan:
- Preset pulse → cmd_ready=1, busy=0, done=0, j_o=k_o=0x00. Then LOAD data=0xA5 → bank=0xA5 one edge after accept; done pulses the next cycle.
- From 0xA5: TOGGLE data=0x0F → bank=0xAA. Then CLEAR → 0x00. Then SET → 0xFF.
- LOAD 0xFD, then COUNT_UP cnt=4 → bank reads 0xFE, 0xFF, 0x00, 0x01 on successive edges. done occurs once, exactly 4 edges after accept; busy is high throughout.
- LOAD 0x02, then COUNT_DOWN cnt=3 → 0x01, 0x00, 0xFF. Then COUNT_UP cnt=0 → bank stays 0xFF; done 2 cycles after accept.
- LOAD 0x81, then SHIFT_L data[0]=1 cnt=2 → 0x03, then 0x07. Hold cmd_valid high with a new command during EXEC/DONE → it is not accepted until cmd_ready=1.
- COUNT_UP cnt=200 from 0x00, with preset asserted after 10 steps → outputs go to reset values immediately; bank holds 0x0A; no done; the next command is accepted normally.
